// File: rtl/param_stack.sv
// Parametrised LIFO stack with status, sticky error flags and registered pop.
// Optional high-water mark output enabled by PARAM_STACK_HIGH_WATER_EN.
module param_stack #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH = 256,
    localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
`ifdef PARAM_STACK_HIGH_WATER_EN
    ,
    output logic [CNT_WIDTH-1:0]  high_water
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic [AW-1:0]        top_addr;
    logic [AW-1:0]        mem_addr;
    logic                 mem_we;
    logic                 take;
    logic                 bypass;
    logic                 ovf_set;
    logic                 unf_set;

    assign empty    = (count == '0);
    assign full     = (count == CNT_FULL);
    assign top_addr = AW'(count - CNT_ONE);

    always_comb begin
        cnt_nxt  = count;
        mem_addr = AW'(count);
        mem_we   = 1'b0;
        take     = 1'b0;
        bypass   = 1'b0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        unique case (1'b1)
            push && !pop: begin
                if (full) begin
                    ovf_set = 1'b1;
                end else begin
                    mem_we  = 1'b1;
                    cnt_nxt = count + CNT_ONE;
                end
            end
            !push && pop: begin
                if (empty) begin
                    unf_set = 1'b1;
                end else begin
                    take    = 1'b1;
                    cnt_nxt = count - CNT_ONE;
                end
            end
            push && pop: begin
                // Replace-top: read old top and overwrite it in one edge
                if (empty) begin
                    bypass = 1'b1;
                end else begin
                    take     = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = top_addr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_addr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= cnt_nxt;
            pop_valid <= take | bypass;
            if (take) begin
                pop_data <= mem[top_addr];
            end else if (bypass) begin
                pop_data <= push_data;
            end
            // A fresh error beats a simultaneous clear
            overflow  <= ovf_set | (overflow & ~err_clr);
            underflow <= unf_set | (underflow & ~err_clr);
        end
    end

`ifdef PARAM_STACK_HIGH_WATER_EN
    logic [CNT_WIDTH-1:0] hw_base;

    assign hw_base = err_clr ? count : high_water;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_water <= '0;
        end else begin
            high_water <= (cnt_nxt > hw_base) ? cnt_nxt : hw_base;
        end
    end
`endif

endmodule

// File: doc/param_stack.md
Name: param_stack

Overview:
- Parametrised LIFO stack with configurable width and depth.
- Successor to the fixed 8-bit/256-entry stack component; used as the call/return and data stack in the CPU datapath.
- Adds full/empty status, an occupancy count, sticky overflow/underflow error flags, a registered pop output with a valid strobe, and defined simultaneous push+pop (replace-top) behaviour.

Parameters:
- DATA_WIDTH, 8, bit width of each stack entry.
- DEPTH, 256, number of entries; any integer >= 2.
- CNT_WIDTH, $clog2(DEPTH+1), width of the occupancy count; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- push  input  1  push request, sampled on the clk edge.
- pop  input  1  pop request, sampled on the clk edge.
- push_data  input  DATA_WIDTH  value to push.
- err_clr  input  1  clears the sticky error flags.
- pop_data  output  DATA_WIDTH  registered popped value.
- pop_valid  output  1  high for one cycle when pop_data was updated by a successful pop.
- count  output  CNT_WIDTH  current number of entries.
- empty  output  1  count == 0; combinational from count.
- full  output  1  count == DEPTH; combinational from count.
- overflow  output  1  sticky; set by a push while full.
- underflow  output  1  sticky; set by a pop while empty.

Behaviour:
- Reset is asynchronous and active-high:
  - count=0, pop_data=0, pop_valid=0, overflow=0, underflow=0; empty=1, full=0.
  - Storage array is not reset.
  - Reset asserted mid-operation discards any in-flight request and forces the reset values immediately.
- Storage: DEPTH x DATA_WIDTH array written synchronously. Entry index count-1 is the top.
- Latency: pop_data and pop_valid update on the same edge that samples pop. The pop result is visible one cycle after the request.
- pop_valid defaults to 0 every cycle unless set by one of the cases below.
- Cases, evaluated per clk edge:
  - Idle (push=0, pop=0): no state change.
  - Push only, not full: mem[count] <= push_data; count <= count+1.
  - Push only, full: push dropped; storage and count unchanged; overflow <= 1.
  - Pop only, not empty: pop_data <= mem[count-1]; pop_valid <= 1; count <= count-1.
  - Pop only, empty: pop_data holds; pop_valid stays 0; underflow <= 1.
  - Push+pop, not empty (this includes full): pop_data <= mem[count-1]; pop_valid <= 1; mem[count-1] <= push_data; count unchanged. No overflow, even when full.
  - Push+pop, empty: bypass. pop_data <= push_data; pop_valid <= 1; count stays 0; no error.
- Popped entries are not cleared. Values above the top are don't-care.
- Error flags:
  - err_clr=1 clears overflow and underflow.
  - If a new error occurs in the same cycle as err_clr, the new error wins and that flag ends at 1.
- Count arithmetic is CNT_WIDTH wide. It never wraps, because the full/empty guards prevent it.

Optional Feature:
- Macro: PARAM_STACK_HIGH_WATER_EN.
- Defined:
  - Adds output high_water (CNT_WIDTH), reset to 0.
  - Each edge, high_water <= max(high_water, next count).
  - err_clr also resets high_water to the current count.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan (all with DATA_WIDTH=8, DEPTH=4):
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles, then pop three times -> pop_data 0x33, 0x22, 0x11, each with a one-cycle pop_valid=1 strobe; count 3->0; empty=1 at the end.
- Push 0xA0..0xA3 to reach full=1, then push 0xFF -> count stays 4, overflow=1. Next pop returns 0xA3.
- Pop while empty -> underflow=1, pop_valid=0, pop_data unchanged. Then err_clr=1 together with another empty pop -> underflow remains 1. Then err_clr alone -> underflow=0.
- Stack holds [0x01, 0x02]; push 0x55 with pop -> pop_data=0x02, pop_valid=1, count=2. Following pop -> 0x55.
- Empty stack; push 0x7E with pop -> pop_data=0x7E, pop_valid=1, count=0, no error flags. Full stack with push+pop -> replace top, overflow stays 0.
- Push twice, then assert rst asynchronously between clock edges -> count=0, pop_data=0, pop_valid=0, flags=0 immediately. With PARAM_STACK_HIGH_WATER_EN defined, high_water=0 after reset and 4 after filling the stack.
